// File: rtl/btn_conditioner.sv
// Multi-channel pushbutton conditioner: synchroniser, debounce FSM and
// press / typematic / hold / release pulse generation per channel.
module btn_conditioner #(
  parameter int NCH           = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYC       = 2**15,
  parameter int REPEAT_DELAY  = 2**22,
  parameter int REPEAT_PERIOD = 2**20
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [NCH-1:0] pb,
  input  logic [NCH-1:0] rpt_en,
  output logic [NCH-1:0] dpb,
  output logic [NCH-1:0] scen,
  output logic [NCH-1:0] mcen,
  output logic [NCH-1:0] ccen,
  output logic [NCH-1:0] rel
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int RW = $clog2(RMAX + 1);
  localparam int PW = $clog2(REPEAT_PERIOD + 1);

  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC);
  localparam logic [DW-1:0] DEB_ONE = DW'(1);
  localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_PER = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] RPT_ONE = RW'(1);
  localparam logic [PW-1:0] PER_VAL = PW'(REPEAT_PERIOD);
  localparam logic [PW-1:0] PER_ONE = PW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PDEB,
    HELD,
    RDEB
  } state_t;

  logic [NCH-1:0] sync [SYNC_STAGES];
  logic [NCH-1:0] s;
  state_t         st      [NCH];
  logic [DW-1:0]  deb_cnt [NCH];
  logic [RW-1:0]  rpt_cnt [NCH];
  logic [PW-1:0]  per_cnt [NCH];

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync[k] <= '0;
      end
      for (int c = 0; c < NCH; c++) begin
        st[c]      <= IDLE;
        deb_cnt[c] <= '0;
        rpt_cnt[c] <= '0;
        per_cnt[c] <= '0;
      end
      dpb  <= '0;
      scen <= '0;
      mcen <= '0;
      ccen <= '0;
      rel  <= '0;
    end else begin
      sync[0] <= pb;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync[k] <= sync[k-1];
      end
      for (int c = 0; c < NCH; c++) begin
        scen[c] <= 1'b0;
        mcen[c] <= 1'b0;
        ccen[c] <= 1'b0;
        rel[c]  <= 1'b0;
        unique case (st[c])
          IDLE: begin
            if (s[c]) begin
              st[c]      <= PDEB;
              deb_cnt[c] <= DEB_ONE;
            end
          end
          PDEB: begin
            if (!s[c]) begin
              st[c] <= IDLE;
            end else if (deb_cnt[c] == DEB_MAX) begin
              st[c]      <= HELD;
              dpb[c]     <= 1'b1;
              scen[c]    <= 1'b1;
              mcen[c]    <= 1'b1;
              ccen[c]    <= 1'b1;
              rpt_cnt[c] <= RPT_DLY;
              per_cnt[c] <= PER_VAL;
            end else begin
              deb_cnt[c] <= deb_cnt[c] + DEB_ONE;
            end
          end
          HELD: begin
            // Counters still run on the cycle that spots the release.
            if (per_cnt[c] == PER_ONE) begin
              ccen[c]    <= 1'b1;
              per_cnt[c] <= PER_VAL;
            end else begin
              per_cnt[c] <= per_cnt[c] - PER_ONE;
            end
            if (rpt_cnt[c] == RPT_ONE) begin
              mcen[c]    <= rpt_en[c];
              rpt_cnt[c] <= RPT_PER;
            end else begin
              rpt_cnt[c] <= rpt_cnt[c] - RPT_ONE;
            end
            if (!s[c]) begin
              st[c]      <= RDEB;
              deb_cnt[c] <= DEB_ONE;
            end
          end
          RDEB: begin
            if (s[c]) begin
              st[c] <= HELD;
            end else if (deb_cnt[c] == DEB_MAX) begin
              st[c]  <= IDLE;
              dpb[c] <= 1'b0;
              rel[c] <= 1'b1;
            end else begin
              deb_cnt[c] <= deb_cnt[c] + DEB_ONE;
            end
          end
          default: st[c] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a window/tick based
// reference model checked every cycle, plus literal timing checks.
module tb_btn_conditioner;

  localparam int NCH  = 2;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DLY  = 10;
  localparam int PER  = 3;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic [NCH-1:0] pb = '0;
  logic [NCH-1:0] rpt_en = '1;
  logic [NCH-1:0] dpb, scen, mcen, ccen, rel;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  btn_conditioner #(
    .NCH(NCH), .SYNC_STAGES(SYNC), .DEB_CYC(DEB),
    .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pb(pb), .rpt_en(rpt_en),
    .dpb(dpb), .scen(scen), .mcen(mcen), .ccen(ccen), .rel(rel)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  bit pipe  [NCH][SYNC];
  bit win   [NCH][DEB+1];
  bit m_dpb [NCH];
  bit s_prv [NCH];
  int ticks [NCH];
  logic [NCH-1:0] e_dpb = '0, e_scen = '0, e_mcen = '0;
  logic [NCH-1:0] e_ccen = '0, e_rel = '0;

  task automatic check(string name, logic [NCH-1:0] act,
                       logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: s is pb delayed by SYNC edges; dpb flips once DEB+1
  // consecutive s samples disagree with it; while held-and-stable
  // each edge is one tick and pulses follow from tick arithmetic.
  task automatic model_step(logic [NCH-1:0] p, logic [NCH-1:0] r,
                            logic rs);
    for (int c = 0; c < NCH; c++) begin
      e_scen[c] = 0; e_mcen[c] = 0; e_ccen[c] = 0; e_rel[c] = 0;
      if (rs) begin
        for (int k = 0; k < SYNC; k++) pipe[c][k] = 0;
        for (int k = 0; k <= DEB; k++) win[c][k] = 0;
        m_dpb[c] = 0; s_prv[c] = 0; ticks[c] = 0;
      end else begin
        bit s, held, flip;
        s = pipe[c][SYNC-1];
        for (int k = SYNC-1; k > 0; k--) pipe[c][k] = pipe[c][k-1];
        pipe[c][0] = p[c];
        held = m_dpb[c] && s_prv[c];
        for (int k = DEB; k > 0; k--) win[c][k] = win[c][k-1];
        win[c][0] = s;
        flip = 1;
        for (int k = 0; k <= DEB; k++)
          if (win[c][k] == m_dpb[c]) flip = 0;
        if (flip && !m_dpb[c]) begin
          m_dpb[c] = 1; ticks[c] = 0;
          e_scen[c] = 1; e_mcen[c] = 1; e_ccen[c] = 1;
        end else if (flip) begin
          m_dpb[c] = 0; e_rel[c] = 1;
        end else if (held) begin
          ticks[c]++;
          e_ccen[c] = (ticks[c] % PER) == 0;
          e_mcen[c] = r[c] && ticks[c] >= DLY &&
                      ((ticks[c] - DLY) % PER) == 0;
        end
        s_prv[c] = s;
      end
      e_dpb[c] = m_dpb[c];
    end
  endtask

  always @(negedge Clk) begin
    if (armed) begin
      check("dpb", dpb, e_dpb);
      check("scen", scen, e_scen);
      check("mcen", mcen, e_mcen);
      check("ccen", ccen, e_ccen);
      check("rel", rel, e_rel);
    end
  end

  task automatic tick(logic [NCH-1:0] p, logic [NCH-1:0] r, logic rs);
    pb = p; rpt_en = r; Reset = rs;
    model_step(p, r, rs);
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick('0, '1, 1'b0);
  endtask

  initial begin
    logic [NCH-1:0] p;
    for (int i = 0; i < 3; i++) tick('0, '1, 1'b1);
    armed = 1'b1;
    check("rst_dpb", dpb, 2'b00);
    check("rst_pulses", scen | mcen | ccen | rel, 2'b00);
    idle(3);

    // 1 clean hold
    for (int t = 0; t < 56; t++) begin
      p = {1'b0, t < 40};
      tick(p, 2'b11, 1'b0);
      if (t == 6) begin
        check("t1_dpb6", dpb, 2'b01);
        check("t1_scen6", scen, 2'b01);
        check("t1_mcen6", mcen, 2'b01);
        check("t1_ccen6", ccen, 2'b01);
      end
      if (t == 9)  check("t1_ccen9", ccen, 2'b01);
      if (t == 16) check("t1_mcen16", mcen, 2'b01);
      if (t == 19) check("t1_mcen19", mcen, 2'b01);
      if (t == 45) check("t1_dpb45", dpb, 2'b01);
      if (t == 46) begin
        check("t1_rel46", rel, 2'b01);
        check("t1_dpb46", dpb, 2'b00);
      end
    end

    // 2 press bounce
    for (int t = 0; t < 46; t++) begin
      p = {1'b0, (t < 4) ? (t % 2 == 0) : (t < 30)};
      tick(p, 2'b11, 1'b0);
      if (t == 9)  check("t2_dpb9", dpb, 2'b00);
      if (t == 10) check("t2_scen10", scen, 2'b01);
    end

    // 3 release bounce while held
    for (int t = 0; t < 56; t++) begin
      p = {1'b0, t < 40 && t != 20 && t != 21};
      tick(p, 2'b11, 1'b0);
      if (t == 22) check("t3_mcen22", mcen, 2'b01);
      if (t == 23) check("t3_dpb23", dpb, 2'b01);
      if (t == 25) check("t3_rel25", rel, 2'b00);
      if (t == 26) check("t3_ccen26", ccen, 2'b01);
      if (t == 27) check("t3_mcen27", mcen, 2'b01);
    end

    // 4 typematic disabled
    for (int t = 0; t < 56; t++) begin
      p = {1'b0, t < 40};
      tick(p, 2'b00, 1'b0);
      if (t == 6)  check("t4_mcen6", mcen, 2'b01);
      if (t == 15) check("t4_ccen15", ccen, 2'b01);
      if (t == 16) check("t4_mcen16", mcen, 2'b00);
    end

    // 5 two channels, ch1 released early
    for (int t = 0; t < 46; t++) begin
      p = {t < 12, t < 30};
      tick(p, 2'b11, 1'b0);
      if (t == 6)  check("t5_scen6", scen, 2'b11);
      if (t == 18) check("t5_rel18", rel, 2'b10);
      if (t == 36) check("t5_rel36", rel, 2'b01);
    end

    // 6 reset mid-hold
    for (int t = 0; t < 56; t++) begin
      p = {1'b0, t < 40};
      tick(p, 2'b11, t == 20);
      if (t == 20) begin
        check("t6_dpb20", dpb, 2'b00);
        check("t6_out20", scen | mcen | ccen | rel, 2'b00);
      end
      if (t == 26) check("t6_scen26", scen, 2'b00);
      if (t == 27) check("t6_scen27", scen, 2'b01);
    end

    idle(4);
    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
